// File: rtl/decode_stage.sv
// Decode stage: register file with write-through bypass, load-use hazard
// detection, and the D->E pipeline register with flush/stall/bubble control.
module decode_stage #(
    parameter  int unsigned XLEN   = 32,
    parameter  int unsigned NREG   = 32,
    parameter  int unsigned CTRL_W = 12,
    localparam int unsigned REG_AW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [31:0]       instr_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic              valid_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic              mem_read_d,
    input  logic [XLEN-1:0]   imm_d,

    input  logic              reg_write_w,
    input  logic [REG_AW-1:0] rd_w,
    input  logic [XLEN-1:0]   result_w,

    input  logic              flush_e,
    input  logic              stall_in,

    output logic              valid_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic              mem_read_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   imm_e,
    output logic [XLEN-1:0]   r1_e,
    output logic [XLEN-1:0]   r2_e,
    output logic [REG_AW-1:0] rs1_e,
    output logic [REG_AW-1:0] rs2_e,
    output logic [REG_AW-1:0] rd_e,

    output logic              stall_d
);

    // Register-field decode; opcode/funct bits are not needed here.
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic              unused_instr_bits;

    assign rs1 = REG_AW'(instr_d[19:15]);
    assign rs2 = REG_AW'(instr_d[24:20]);
    assign rd  = REG_AW'(instr_d[11:7]);
    assign unused_instr_bits = ^{instr_d[31:25], instr_d[14:12], instr_d[6:0]};

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rf_q [NREG];
    logic            rf_we;
    logic [XLEN-1:0] r1, r2;

    assign rf_we = reg_write_w && (rd_w != '0);

    // Synchronous write port; x0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[rd_w] <= result_w;
        end
    end

    // Combinational reads with same-cycle writeback bypass.
    always_comb begin
        r1 = '0;
        r2 = '0;
        if (rs1 != '0) begin
            r1 = (rf_we && (rd_w == rs1)) ? result_w : rf_q[rs1];
        end
        if (rs2 != '0) begin
            r2 = (rf_we && (rd_w == rs2)) ? result_w : rf_q[rs2];
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic hazard;

    // A load in E whose destination is read by D cannot be forwarded in time.
    always_comb begin
        hazard = valid_e && mem_read_e && (rd_e != '0) && valid_d &&
                 ((rd_e == rs1) || (rd_e == rs2));
        stall_d = hazard || stall_in;
    end

    // ------------------------------------------------------------------
    // D->E pipeline register
    // ------------------------------------------------------------------
    logic              valid_q,    valid_d_nxt;
    logic [CTRL_W-1:0] ctrl_q,     ctrl_d_nxt;
    logic              mem_read_q, mem_read_d_nxt;
    logic [XLEN-1:0]   pc_q,       pc_d_nxt;
    logic [XLEN-1:0]   imm_q,      imm_d_nxt;
    logic [XLEN-1:0]   r1_q,       r1_d_nxt;
    logic [XLEN-1:0]   r2_q,       r2_d_nxt;
    logic [REG_AW-1:0] rs1_q,      rs1_d_nxt;
    logic [REG_AW-1:0] rs2_q,      rs2_d_nxt;
    logic [REG_AW-1:0] rd_q,       rd_d_nxt;

    // Next-state: flush beats stall beats hazard bubble beats normal load.
    // Flush and bubble only clear the control bits; data fields keep stale
    // values since nothing downstream looks at them while valid_e is low.
    always_comb begin
        valid_d_nxt    = valid_q;
        ctrl_d_nxt     = ctrl_q;
        mem_read_d_nxt = mem_read_q;
        pc_d_nxt       = pc_q;
        imm_d_nxt      = imm_q;
        r1_d_nxt       = r1_q;
        r2_d_nxt       = r2_q;
        rs1_d_nxt      = rs1_q;
        rs2_d_nxt      = rs2_q;
        rd_d_nxt       = rd_q;
        if (flush_e || (!stall_in && hazard)) begin
            valid_d_nxt    = 1'b0;
            ctrl_d_nxt     = '0;
            mem_read_d_nxt = 1'b0;
        end else if (!stall_in) begin
            valid_d_nxt    = valid_d;
            ctrl_d_nxt     = valid_d ? ctrl_d : '0;
            mem_read_d_nxt = valid_d && mem_read_d;
            pc_d_nxt       = pc_d;
            imm_d_nxt      = imm_d;
            r1_d_nxt       = r1;
            r2_d_nxt       = r2;
            rs1_d_nxt      = rs1;
            rs2_d_nxt      = rs2;
            rd_d_nxt       = rd;
        end
    end

    // E-stage state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            mem_read_q <= 1'b0;
            pc_q       <= '0;
            imm_q      <= '0;
            r1_q       <= '0;
            r2_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
        end else begin
            valid_q    <= valid_d_nxt;
            ctrl_q     <= ctrl_d_nxt;
            mem_read_q <= mem_read_d_nxt;
            pc_q       <= pc_d_nxt;
            imm_q      <= imm_d_nxt;
            r1_q       <= r1_d_nxt;
            r2_q       <= r2_d_nxt;
            rs1_q      <= rs1_d_nxt;
            rs2_q      <= rs2_d_nxt;
            rd_q       <= rd_d_nxt;
        end
    end

    // Drive the E outputs straight from the state register.
    always_comb begin
        valid_e    = valid_q;
        ctrl_e     = ctrl_q;
        mem_read_e = mem_read_q;
        pc_e       = pc_q;
        imm_e      = imm_q;
        r1_e       = r1_q;
        r2_e       = r2_q;
        rs1_e      = rs1_q;
        rs2_e      = rs2_q;
        rd_e       = rd_q;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath and register width.
REQ-002 Parameter NREG, default 32: architectural register count; REG_AW = clog2(NREG).
REQ-003 Parameter CTRL_W, default 12: width of the opaque control bundle from the control unit.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 instr_d  in  32  instruction in D stage.
REQ-007 pc_d  in  XLEN  PC of instr_d.
REQ-008 valid_d  in  1  instr_d is a real instruction.
REQ-009 ctrl_d  in  CTRL_W  decoded control bundle for instr_d.
REQ-010 mem_read_d  in  1  instr_d is a load.
REQ-011 imm_d  in  XLEN  generated immediate for instr_d.
REQ-012 reg_write_w  in  1  writeback enable.
REQ-013 rd_w  in  REG_AW  writeback destination.
REQ-014 result_w  in  XLEN  writeback data.
REQ-015 flush_e  in  1  kill the instruction entering E (taken branch or jump).
REQ-016 stall_in  in  1  downstream stall; E must hold.
REQ-017 Outputs to E: valid_e 1, ctrl_e CTRL_W, mem_read_e 1, pc_e XLEN, imm_e XLEN, r1_e XLEN, r2_e XLEN, rs1_e REG_AW, rs2_e REG_AW, rd_e REG_AW; all registered.
REQ-018 stall_d  out  1  combinational; hold F and D stages.

Function
REQ-019 Field extraction: rs1 = instr_d[19:15], rs2 = instr_d[24:20], rd = instr_d[11:7], truncated or zero-extended to REG_AW.
REQ-020 Register file is NREG x XLEN with 2 combinational reads and 1 synchronous write on the rising edge when reg_write_w=1 and rd_w!=0.
REQ-021 Register 0 always reads 0; writes to register 0 are ignored.
REQ-022 Write-through bypass: when reg_write_w=1, rd_w!=0 and rd_w equals a read address, that read returns result_w in the same cycle.
REQ-023 Load-use hazard = valid_e & mem_read_e & (rd_e!=0) & valid_d & ((rd_e==rs1) | (rd_e==rs2)); rs2 is compared for every format.
REQ-024 stall_d = hazard | stall_in.
REQ-025 E-register update priority per edge, highest first: flush_e, stall_in, hazard, normal.
REQ-026 flush_e=1: valid_e, ctrl_e and mem_read_e load 0; the data fields (pc_e, imm_e, r1_e, r2_e, rs1_e, rs2_e, rd_e) hold their previous values.
REQ-027 stall_in=1 and flush_e=0: every E register holds its previous value.
REQ-028 Hazard only: a bubble is inserted with the same effect as REQ-026; the D-stage instruction is re-presented next cycle because stall_d=1.
REQ-029 Normal: all E registers load their D-stage values; valid_e <= valid_d; ctrl_e and mem_read_e load 0 when valid_d=0.
REQ-030 Latency: an instruction presented in D with no stall or flush appears on the E outputs one cycle later.
REQ-031 While E holds, r1_e/r2_e are not refreshed by writeback; staleness is resolved by the downstream forwarding unit.
REQ-032 Register-file writes proceed regardless of stall, flush or hazard.

Reset
REQ-033 While rst=0, all E outputs are 0 and all register-file entries are 0, asynchronously.
REQ-034 With all E outputs 0 during reset, stall_d = stall_in.
REQ-035 The first capture after rst deasserts follows REQ-025.

Verification
REQ-036 Write x5=0xDEADBEEF, then present add x1,x5,x0 with valid_d=1 -> next cycle r1_e=0xDEADBEEF, r2_e=0, rd_e=1, valid_e=1.
REQ-037 reg_write_w=1, rd_w=7, result_w=0x1234 in the same cycle that instr_d reads rs1=7 -> r1_e=0x1234 next edge; a write to x0 leaves x0 reading 0.
REQ-038 E holds lw x3 (mem_read_e=1) and D presents rs2=3 -> stall_d=1, next cycle valid_e=0 and ctrl_e=0; the following cycle the consumer enters E with valid_e=1.
REQ-039 flush_e=1 and stall_in=1 together -> valid_e=0; pc_e is unchanged.
REQ-040 stall_in=1 for 3 cycles with changing D inputs -> all E outputs stay constant and stall_d=1 throughout.
REQ-041 Assert rst low mid-stream with valid_e=1 -> all outputs are 0 immediately, and every register reads 0 after release.
